trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Sequences M-mode trap entry and MRET return for the cotm32 core. It arbitrates synchronous exceptions against enabled machine interrupts and flushes the pipeline. It then performs the mepc/mcause/mtval/mstatus updates through the single CSR write port, one per cycle, and redirects fetch to the handler or to mepc. It sits between the pipeline hazard logic and the CSR file, and drives the core-wide trap-mode flag.

## Interface
- XLEN, 32, datapath and CSR width
- i_clk  in  1  core clock
- i_rst  in  1  reset; asynchronous, active-high
- i_exc_valid  in  1  synchronous exception from the pipeline (held while o_busy)
- i_exc_cause  in  5  exception code
- i_exc_pc  in  XLEN  PC of the faulting instruction
- i_exc_tval  in  XLEN  trap value
- i_irq_mei / i_irq_msi / i_irq_mti  in  1 each  pending external / software / timer interrupt
- i_cur_pc  in  XLEN  PC of the oldest uncommitted instruction (interrupt mepc)
- i_mret  in  1  MRET at commit
- i_mstatus, i_mie, i_mtvec, i_mepc  in  XLEN each  current CSR values
- o_flush  out  1  kill in-flight instructions
- o_busy  out  1  stall fetch/commit
- o_csr_we  out  1  CSR write strobe
- o_csr_addr  out  12  CSR write address
- o_csr_wdata  out  XLEN  CSR write data
- o_redirect  out  1  PC redirect strobe
- o_redirect_pc  out  XLEN  redirect target
- o_trap_mode  out  1  high from trap entry until MRET completes

## Operation
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, SAVE_STATUS, RET_STATUS, REDIRECT.
- Request priority in IDLE: exception > MEI (cause 11) > MSI (3) > MTI (7) > MRET.
- An interrupt is eligible only when mstatus.MIE (bit 3), the matching mie bit and the pending line are all 1.
- Accepted trap in IDLE:
  - registers epc (i_exc_pc for an exception, i_cur_pc for an interrupt), cause (bit XLEN-1 = 1 for an interrupt), tval (0 for an interrupt) and the target;
  - asserts o_flush that cycle;
  - goes to SAVE_EPC.
- SAVE_EPC writes mepc (0x341), SAVE_CAUSE writes mcause (0x342) and SAVE_TVAL writes mtval (0x343), each with the registered values.
- SAVE_STATUS writes mstatus (0x300) with MPIE (bit 7) = old MIE, MIE = 0 and MPP[12:11] = 2'b11. Old MIE comes from i_mstatus sampled at acceptance.
- Accepted MRET in IDLE asserts o_flush and goes to RET_STATUS. That state writes mstatus with MIE = MPIE, MPIE = 1 and MPP = 2'b11, then goes to REDIRECT with the target i_mepc sampled at acceptance.
- REDIRECT pulses o_redirect with o_redirect_pc, then returns to IDLE.
- Trap target: {i_mtvec[XLEN-1:2], 2'b00}, plus vectoring per Configuration. mepc is written with bits [1:0] forced to 0.
- Exception and MRET in the same cycle: exception wins and MRET is dropped.
- Requests while not IDLE are ignored. The pipeline holds them under o_busy, so they are re-arbitrated on the return to IDLE.
- A trap while o_trap_mode = 1 is legal: it re-enters and overwrites the CSRs.

## Timing
- Reset (async): state IDLE, every output 0, registered epc/cause/tval/target 0.
- Reset mid-sequence aborts immediately with no further CSR writes.
- o_busy = (state != IDLE) | o_flush. o_flush is combinational in the acceptance cycle only.
- o_csr_we is high exactly one cycle per SAVE_*/RET_STATUS state, with address and data valid in that cycle.
- Trap latency: acceptance at cycle N; mepc, mcause, mtval and mstatus writes at N+1 to N+4; o_redirect at N+5; IDLE at N+6.
- MRET latency: acceptance at N; mstatus write at N+1; redirect at N+2.
- o_trap_mode is registered:
  - set at the edge ending REDIRECT of a trap;
  - cleared at the edge ending REDIRECT of an MRET;
  - unchanged otherwise.

## Configuration
- COTM32_VECTORED_IRQ_EN defined: when i_mtvec[1:0] == 2'b01 and the trap is an interrupt, target = base + 4*cause_code. Exceptions always use base.
- COTM32_VECTORED_IRQ_EN undefined: i_mtvec[1:0] is ignored and the target is always base (direct mode).

## Structure
- cotm32_pkg gains:
  - trap_seq_state_e;
  - CSR_MSTATUS/MEPC/MCAUSE/MTVAL address constants;
  - interrupt cause constants (IRQ_MEI=11, IRQ_MSI=3, IRQ_MTI=7);
  - mstatus bit-position constants (MIE=3, MPIE=7, MPP=12:11).
- One combinational sub-module, trap_prio_enc: eligibility masking and priority select, producing valid, is_irq and cause.
- The FSM and registers stay in trap_sequencer.

## Test plan
- Illegal-instruction exception, cause 2, pc 0x100, tval 0xDEAD, mtvec 0x8000, mstatus 0x8 -> writes 0x341=0x100, 0x342=0x2, 0x343=0xDEAD, 0x300=0x1880 on successive cycles; redirect to 0x8000; o_trap_mode=1.
- MRET with mstatus 0x1880 and mepc 0x104 -> 0x300=0x1888; redirect to 0x104 two cycles after acceptance; o_trap_mode=0.
- Exception and MEI simultaneous, MIE=1 -> exception cause is taken; MEI is taken after the return to IDLE with mcause 0x8000000B.
- MTI pending with mstatus.MIE=0 -> no sequence; after MIE is set -> trap with mcause 0x80000007.
- mtvec 0x8001 with MTI: with COTM32_VECTORED_IRQ_EN defined, redirect to 0x801C; without it, redirect to 0x8000.
- Assert i_rst during SAVE_CAUSE -> all outputs 0 immediately; no mtval or mstatus write ever occurs.

Source files
------------

// File: rtl/cotm32_pkg.sv
// cotm32_pkg: shared types and constants for the cotm32 trap machinery.
//   trap_seq_state_e : trap sequencer FSM states
//   CSR_*            : machine-mode CSR addresses written by the sequencer
//   IRQ_*            : machine interrupt cause codes (also their mie/mip bit index)
//   MSTATUS_*        : mstatus bit positions
package cotm32_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SAVE_EPC    = 3'd1,
    SAVE_CAUSE  = 3'd2,
    SAVE_TVAL   = 3'd3,
    SAVE_STATUS = 3'd4,
    RET_STATUS  = 3'd5,
    REDIRECT    = 3'd6
  } trap_seq_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [4:0] IRQ_MEI = 5'd11;
  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: combinational trap request arbiter.
// Masks the interrupt lines with mstatus.MIE and the matching mie bit, then
// picks exception > MEI > MSI > MTI.
// Ports:
//   exc_valid_i, exc_cause_i : synchronous exception request and code
//   irq_mei_i/msi_i/mti_i    : pending interrupt lines
//   mstatus_mie_i            : global machine interrupt enable
//   mie_i                    : mie CSR (bits 11/3/7 used)
//   valid_o, is_irq_o, cause_o : selected request, interrupt flag, cause code
module trap_prio_enc
  import cotm32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            exc_valid_i,
  input  logic [4:0]      exc_cause_i,
  input  logic            irq_mei_i,
  input  logic            irq_msi_i,
  input  logic            irq_mti_i,
  input  logic            mstatus_mie_i,
  input  logic [XLEN-1:0] mie_i,
  output logic            valid_o,
  output logic            is_irq_o,
  output logic [4:0]      cause_o
);

  logic mei_ok, msi_ok, mti_ok;
  logic unused_mie;

  assign mei_ok = mstatus_mie_i & mie_i[IRQ_MEI] & irq_mei_i;
  assign msi_ok = mstatus_mie_i & mie_i[IRQ_MSI] & irq_msi_i;
  assign mti_ok = mstatus_mie_i & mie_i[IRQ_MTI] & irq_mti_i;

  // Only the three machine interrupt enables matter here.
  assign unused_mie = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

  always_comb begin
    valid_o  = 1'b0;
    is_irq_o = 1'b0;
    cause_o  = 5'd0;
    if (exc_valid_i) begin
      valid_o = 1'b1;
      cause_o = exc_cause_i;
    end else if (mei_ok) begin
      valid_o  = 1'b1;
      is_irq_o = 1'b1;
      cause_o  = IRQ_MEI;
    end else if (msi_ok) begin
      valid_o  = 1'b1;
      is_irq_o = 1'b1;
      cause_o  = IRQ_MSI;
    end else if (mti_ok) begin
      valid_o  = 1'b1;
      is_irq_o = 1'b1;
      cause_o  = IRQ_MTI;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: M-mode trap entry / MRET sequencer for the cotm32 core.
// On an accepted trap it flushes, then writes mepc, mcause, mtval, mstatus
// (one CSR per cycle) and redirects fetch to the handler. On MRET it writes
// mstatus and redirects to mepc. o_trap_mode tracks "inside a handler".
// Optional feature macro: COTM32_VECTORED_IRQ_EN (vectored interrupt targets
// when mtvec[1:0] == 2'b01); undefined means direct mode only.
// Ports:
//   i_clk, i_rst (async, active-high)
//   i_exc_*          : exception request, cause, pc, tval
//   i_irq_mei/msi/mti: pending interrupts; i_cur_pc: interrupt mepc
//   i_mret           : MRET at commit
//   i_mstatus/i_mie/i_mtvec/i_mepc : current CSR values
//   o_flush, o_busy  : pipeline control
//   o_csr_we/addr/wdata : single CSR write port
//   o_redirect, o_redirect_pc : fetch redirect
//   o_trap_mode      : core-wide trap-mode flag
//   o_dbg_state      : FSM state for observation
// Handshake: a request is consumed in the cycle o_flush is high (state IDLE);
// while o_busy is high the pipeline holds its requests unchanged and they are
// re-arbitrated once the sequencer is back in IDLE.
module trap_sequencer
  import cotm32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_exc_valid,
  input  logic [4:0]      i_exc_cause,
  input  logic [XLEN-1:0] i_exc_pc,
  input  logic [XLEN-1:0] i_exc_tval,
  input  logic            i_irq_mei,
  input  logic            i_irq_msi,
  input  logic            i_irq_mti,
  input  logic [XLEN-1:0] i_cur_pc,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_mstatus,
  input  logic [XLEN-1:0] i_mie,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  output logic            o_flush,
  output logic            o_busy,
  output logic            o_csr_we,
  output logic [11:0]     o_csr_addr,
  output logic [XLEN-1:0] o_csr_wdata,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_trap_mode,
  output trap_seq_state_e o_dbg_state
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  trap_seq_state_e state_q;
  logic [XLEN-1:0] epc_q, cause_q, tval_q, target_q, status_q;
  logic            ret_q;
  logic            csr_we_q, redirect_q, trap_mode_q;
  logic [11:0]     csr_addr_q;
  logic [XLEN-1:0] csr_wdata_q, redirect_pc_q;

  logic            req_valid, req_irq;
  logic [4:0]      req_cause;
  logic            accept_trap, accept_mret;
  logic [XLEN-1:0] epc_d, cause_d, tval_d, trap_base, target_d;
  logic [XLEN-1:0] trap_status_d, ret_status_d;

  trap_prio_enc #(.XLEN(XLEN)) u_prio (
    .exc_valid_i   (i_exc_valid),
    .exc_cause_i   (i_exc_cause),
    .irq_mei_i     (i_irq_mei),
    .irq_msi_i     (i_irq_msi),
    .irq_mti_i     (i_irq_mti),
    .mstatus_mie_i (i_mstatus[MSTATUS_MIE]),
    .mie_i         (i_mie),
    .valid_o       (req_valid),
    .is_irq_o      (req_irq),
    .cause_o       (req_cause)
  );

  // An exception in the same cycle as MRET wins; the MRET is dropped.
  assign accept_trap = (state_q == IDLE) & req_valid;
  assign accept_mret = (state_q == IDLE) & ~req_valid & i_mret;

  // Gated by reset so every output reads 0 while reset is asserted.
  assign o_flush = ~i_rst & (accept_trap | accept_mret);
  assign o_busy  = (state_q != IDLE) | o_flush;

  assign epc_d     = (req_irq ? i_cur_pc : i_exc_pc) & ALIGN_MASK;
  assign cause_d   = {req_irq, {(XLEN-6){1'b0}}, req_cause};
  assign tval_d    = req_irq ? '0 : i_exc_tval;
  assign trap_base = i_mtvec & ALIGN_MASK;

`ifdef COTM32_VECTORED_IRQ_EN
  assign target_d = (req_irq && (i_mtvec[1:0] == 2'b01))
                  ? trap_base + {{(XLEN-7){1'b0}}, req_cause, 2'b00}
                  : trap_base;
`else
  assign target_d = trap_base;
`endif

  always_comb begin
    trap_status_d = i_mstatus;
    trap_status_d[MSTATUS_MPIE] = i_mstatus[MSTATUS_MIE];
    trap_status_d[MSTATUS_MIE]  = 1'b0;
    trap_status_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    ret_status_d = i_mstatus;
    ret_status_d[MSTATUS_MIE]  = i_mstatus[MSTATUS_MPIE];
    ret_status_d[MSTATUS_MPIE] = 1'b1;
    ret_status_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // Outputs are registered on the transition into the state that owns them,
  // so each CSR write is visible for exactly the cycle spent in that state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      epc_q         <= '0;
      cause_q       <= '0;
      tval_q        <= '0;
      target_q      <= '0;
      status_q      <= '0;
      ret_q         <= 1'b0;
      csr_we_q      <= 1'b0;
      csr_addr_q    <= '0;
      csr_wdata_q   <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      trap_mode_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_trap) begin
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            tval_q      <= tval_d;
            target_q    <= target_d;
            status_q    <= trap_status_d;
            ret_q       <= 1'b0;
            csr_we_q    <= 1'b1;
            csr_addr_q  <= CSR_MEPC;
            csr_wdata_q <= epc_d;
            state_q     <= SAVE_EPC;
          end else if (accept_mret) begin
            target_q    <= i_mepc;
            ret_q       <= 1'b1;
            csr_we_q    <= 1'b1;
            csr_addr_q  <= CSR_MSTATUS;
            csr_wdata_q <= ret_status_d;
            state_q     <= RET_STATUS;
          end
        end
        SAVE_EPC: begin
          csr_addr_q  <= CSR_MCAUSE;
          csr_wdata_q <= cause_q;
          state_q     <= SAVE_CAUSE;
        end
        SAVE_CAUSE: begin
          csr_addr_q  <= CSR_MTVAL;
          csr_wdata_q <= tval_q;
          state_q     <= SAVE_TVAL;
        end
        SAVE_TVAL: begin
          csr_addr_q  <= CSR_MSTATUS;
          csr_wdata_q <= status_q;
          state_q     <= SAVE_STATUS;
        end
        SAVE_STATUS, RET_STATUS: begin
          csr_we_q      <= 1'b0;
          csr_addr_q    <= '0;
          csr_wdata_q   <= '0;
          redirect_q    <= 1'b1;
          redirect_pc_q <= target_q;
          state_q       <= REDIRECT;
        end
        REDIRECT: begin
          redirect_q    <= 1'b0;
          redirect_pc_q <= '0;
          trap_mode_q   <= ~ret_q;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_csr_we      = csr_we_q;
  assign o_csr_addr    = csr_addr_q;
  assign o_csr_wdata   = csr_wdata_q;
  assign o_redirect    = redirect_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_trap_mode   = trap_mode_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed bench for trap_sequencer. Inputs change on the
// falling edge; outputs are checked on the falling edge (plus #1 for the
// combinational flush/busy after inputs change).
module tb_trap_sequencer;
  import cotm32_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            exc_valid;
  logic [4:0]      exc_cause;
  logic [31:0]     exc_pc, exc_tval;
  logic            irq_mei, irq_msi, irq_mti;
  logic [31:0]     cur_pc;
  logic            mret;
  logic [31:0]     mstatus, mie, mtvec, mepc;
  logic            flush, busy, csr_we, redirect, trap_mode;
  logic [11:0]     csr_addr;
  logic [31:0]     csr_wdata, redirect_pc;
  trap_seq_state_e dbg_state;

  int checks = 0;
  int failures = 0;

`ifdef COTM32_VECTORED_IRQ_EN
  localparam logic [31:0] VEC_MTI_TARGET = 32'h0000_801C;
`else
  localparam logic [31:0] VEC_MTI_TARGET = 32'h0000_8000;
`endif

  trap_sequencer #(.XLEN(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_exc_valid   (exc_valid),
    .i_exc_cause   (exc_cause),
    .i_exc_pc      (exc_pc),
    .i_exc_tval    (exc_tval),
    .i_irq_mei     (irq_mei),
    .i_irq_msi     (irq_msi),
    .i_irq_mti     (irq_mti),
    .i_cur_pc      (cur_pc),
    .i_mret        (mret),
    .i_mstatus     (mstatus),
    .i_mie         (mie),
    .i_mtvec       (mtvec),
    .i_mepc        (mepc),
    .o_flush       (flush),
    .o_busy        (busy),
    .o_csr_we      (csr_we),
    .o_csr_addr    (csr_addr),
    .o_csr_wdata   (csr_wdata),
    .o_redirect    (redirect),
    .o_redirect_pc (redirect_pc),
    .o_trap_mode   (trap_mode),
    .o_dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_csr(input string tag, input logic [11:0] addr, input logic [31:0] data);
    chk({tag, "_we"}, {31'd0, csr_we}, 32'd1);
    chk({tag, "_addr"}, {20'd0, csr_addr}, {20'd0, addr});
    chk({tag, "_data"}, csr_wdata, data);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_we"}, {31'd0, csr_we}, 32'd0);
    chk({tag, "_addr"}, {20'd0, csr_addr}, 32'd0);
    chk({tag, "_wdata"}, csr_wdata, 32'd0);
    chk({tag, "_redir"}, {31'd0, redirect}, 32'd0);
    chk({tag, "_rpc"}, redirect_pc, 32'd0);
    chk({tag, "_tmode"}, {31'd0, trap_mode}, 32'd0);
    chk({tag, "_state"}, {29'd0, dbg_state}, {29'd0, IDLE});
  endtask

  // Called right after the acceptance cycle; walks cycles N+1..N+5.
  task automatic run_trap(input string tag, input logic [31:0] e_epc, input logic [31:0] e_cause,
                          input logic [31:0] e_tval, input logic [31:0] e_status,
                          input logic [31:0] e_target);
    @(negedge clk);
    exc_valid = 1'b0;
    mret      = 1'b0;
    #1;
    chk_csr({tag, "_mepc"}, CSR_MEPC, e_epc);
    chk({tag, "_noflush"}, {31'd0, flush}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk_csr({tag, "_mcause"}, CSR_MCAUSE, e_cause);
    @(negedge clk);
    chk_csr({tag, "_mtval"}, CSR_MTVAL, e_tval);
    @(negedge clk);
    chk_csr({tag, "_mstatus"}, CSR_MSTATUS, e_status);
    @(negedge clk);
    chk({tag, "_we_off"}, {31'd0, csr_we}, 32'd0);
    chk({tag, "_redir"}, {31'd0, redirect}, 32'd1);
    chk({tag, "_rpc"}, redirect_pc, e_target);
  endtask

  initial begin
    rst = 1'b1; exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    irq_mei = 1'b0; irq_msi = 1'b0; irq_mti = 1'b0; cur_pc = '0; mret = 1'b0;
    mstatus = '0; mie = '0; mtvec = 32'h8000; mepc = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: illegal instruction exception
    mstatus = 32'h8; exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
    #1;
    chk("t1_flush", {31'd0, flush}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    run_trap("t1", 32'h100, 32'h2, 32'hDEAD, 32'h1880, 32'h8000);
    chk("t1_tmode_pre", {31'd0, trap_mode}, 32'd0);
    @(negedge clk);
    chk("t1_redir_off", {31'd0, redirect}, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);
    chk("t1_tmode", {31'd0, trap_mode}, 32'd1);

    // 2: MRET
    mstatus = 32'h1880; mepc = 32'h104; mret = 1'b1;
    #1;
    chk("t2_flush", {31'd0, flush}, 32'd1);
    @(negedge clk);
    mret = 1'b0;
    #1;
    chk_csr("t2_mstatus", CSR_MSTATUS, 32'h1888);
    chk("t2_tmode_hold", {31'd0, trap_mode}, 32'd1);
    @(negedge clk);
    chk("t2_we_off", {31'd0, csr_we}, 32'd0);
    chk("t2_redir", {31'd0, redirect}, 32'd1);
    chk("t2_rpc", redirect_pc, 32'h104);
    @(negedge clk);
    chk("t2_idle", {31'd0, busy}, 32'd0);
    chk("t2_tmode", {31'd0, trap_mode}, 32'd0);

    // 3: exception + MEI + MRET together; exception wins, MEI follows
    mstatus = 32'h8; mie = 32'h800; irq_mei = 1'b1; cur_pc = 32'h300; mret = 1'b1;
    exc_valid = 1'b1; exc_cause = 5'd5; exc_pc = 32'h203; exc_tval = 32'h44;
    #1;
    chk("t3_flush", {31'd0, flush}, 32'd1);
    run_trap("t3a", 32'h200, 32'h5, 32'h44, 32'h1880, 32'h8000);
    @(negedge clk);
    #1;
    chk("t3_mei_flush", {31'd0, flush}, 32'd1);
    chk("t3_tmode", {31'd0, trap_mode}, 32'd1);
    run_trap("t3b", 32'h300, 32'h8000_000B, 32'h0, 32'h1880, 32'h8000);
    irq_mei = 1'b0;
    @(negedge clk);
    #1;
    chk("t3_idle", {31'd0, busy}, 32'd0);

    // 4: MTI masked by mstatus.MIE, then enabled
    mstatus = 32'h0; mie = 32'h80; irq_mti = 1'b1; cur_pc = 32'h400;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_masked_busy", {31'd0, busy}, 32'd0);
      chk("t4_masked_we", {31'd0, csr_we}, 32'd0);
      @(negedge clk);
    end
    mstatus = 32'h8;
    #1;
    chk("t4_flush", {31'd0, flush}, 32'd1);
    run_trap("t4", 32'h400, 32'h8000_0007, 32'h0, 32'h1880, 32'h8000);
    irq_mti = 1'b0;
    @(negedge clk);
    #1;
    chk("t4_idle", {31'd0, busy}, 32'd0);

    // 5: mtvec mode 01 with MTI
    mtvec = 32'h8001; irq_mti = 1'b1; cur_pc = 32'h500;
    #1;
    chk("t5_flush", {31'd0, flush}, 32'd1);
    run_trap("t5", 32'h500, 32'h8000_0007, 32'h0, 32'h1880, VEC_MTI_TARGET);
    irq_mti = 1'b0;
    @(negedge clk);
    mtvec = 32'h8000;
    #1;
    chk("t5_idle", {31'd0, busy}, 32'd0);

    // 6: reset during SAVE_CAUSE
    exc_valid = 1'b1; exc_cause = 5'd1; exc_pc = 32'h600; exc_tval = 32'h9;
    #1;
    chk("t6_flush", {31'd0, flush}, 32'd1);
    @(negedge clk);
    exc_valid = 1'b0;
    #1;
    chk_csr("t6_mepc", CSR_MEPC, 32'h600);
    @(negedge clk);
    chk_csr("t6_mcause", CSR_MCAUSE, 32'h1);
    rst = 1'b1;
    #1;
    chk_all_zero("t6_rst");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_rst_we", {31'd0, csr_we}, 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_post_we", {31'd0, csr_we}, 32'd0);
      chk("t6_post_busy", {31'd0, busy}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
